// File: rtl/npu_pkg.sv
// Shared NPU constants and types for the pooling-to-FC interface.
// Feature values are signed and stored without modification.
package npu_pkg;

    localparam int DATA_W   = 22;
    localparam int FLAT_LEN = 225;
    localparam int IDX_W    = 8;

    typedef logic signed [DATA_W-1:0] feat_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } flat_state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FLAT_LEN - 1);

endpackage

// File: rtl/flatten_buffer.sv
// Serial-to-parallel flatten buffer feeding the fully connected layer.
// Fills FLAT_LEN entries, pulses o_start, then freezes until the FC reports completion.
module flatten_buffer
    import npu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_valid,
    input  feat_t            i_data,
    output logic             o_ready,
    output feat_t            o_flattened_data [0:FLAT_LEN-1],
    output logic             o_start,
    input  logic             i_result_valid,
    output logic             o_busy,
    output logic             o_overflow,
    output logic [IDX_W-1:0] o_wr_idx
);

    flat_state_e      state_r;
    logic [IDX_W-1:0] wr_idx_r;
    logic             ready_r;
    logic             start_r;
    logic             busy_r;
    logic             overflow_r;
    feat_t            data_r [0:FLAT_LEN-1];

    logic             wr_en_s;
    logic             last_s;

    // Write qualification: only FILL accepts, and a clear in the same cycle wins.
    always_comb begin
        wr_en_s = 1'b0;
        last_s  = 1'b0;
        if ((state_r == FILL) && i_valid && !i_clear) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
        if (wr_idx_r == LAST_IDX) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Entry storage: zeroed only by rst, otherwise overwritten in index order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FLAT_LEN; i++) begin
                data_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < FLAT_LEN; i++) begin
                if (wr_en_s && (wr_idx_r == IDX_W'(i))) begin
                    data_r[i] <= i_data;
                end
            end
        end
    end

    // Frame sequencing with registered handshake, pulse and status outputs.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            state_r    <= FILL;
            wr_idx_r   <= {IDX_W{1'b0}};
            ready_r    <= 1'b1;
            start_r    <= 1'b0;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                FILL: begin
                    start_r <= 1'b0;
                    if (wr_en_s) begin
                        if (last_s) begin
                            wr_idx_r <= {IDX_W{1'b0}};
                            state_r  <= START;
                            ready_r  <= 1'b0;
                            start_r  <= 1'b1;
                            busy_r   <= 1'b1;
                        end else begin
                            wr_idx_r <= wr_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                START: begin
                    // The FC cannot finish this early, so i_result_valid is ignored here.
                    state_r <= WAIT;
                    start_r <= 1'b0;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b1;
                    if (i_valid) begin
                        overflow_r <= 1'b1;
                    end
                end
                WAIT: begin
                    start_r <= 1'b0;
                    if (i_valid) begin
                        overflow_r <= 1'b1;
                    end
                    if (i_result_valid) begin
                        state_r <= FILL;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= FILL;
                    wr_idx_r <= {IDX_W{1'b0}};
                    ready_r  <= 1'b1;
                    start_r  <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready          = ready_r;
    assign o_start          = start_r;
    assign o_busy           = busy_r;
    assign o_overflow       = overflow_r;
    assign o_wr_idx         = wr_idx_r;
    assign o_flattened_data = data_r;

endmodule
